// File: rtl/mips_pkg.sv
// Shared MIPS front-end types: fetch FSM states, queue entry layout and the NOP encoding.
package mips_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/if_prefetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and instruction memory.
interface if_prefetch_if;

    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (output mem_req, mem_addr, input mem_ack, mem_rdata);
    modport slave  (input mem_req, mem_addr, output mem_ack, mem_rdata);

endinterface

// File: rtl/fetch_fifo.sv
// Circular instruction queue; pointers carry an extra wrap bit so full and empty stay distinct.
module fetch_fifo
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush_keep_none,
    input  fetch_entry_t             wdata,
    output fetch_entry_t             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    fetch_entry_t slots [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    // A full queue still takes a push when the head leaves in the same cycle.
    assign do_push = push && (!full || pop) && !flush_keep_none;
    assign do_pop  = pop && !empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign head  = slots[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush_keep_none) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which slots hold valid data.
    always_ff @(posedge clk) begin
        if (do_push) slots[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch front end: fetch PC, request FSM toward instruction memory, redirect flush.
module if_prefetch
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    if_prefetch_if.master        mem,
    input  logic                 redirect,
    input  logic [31:0]          redirect_pc,
    input  logic                 stall,
    output logic                 inst_valid,
    output logic [31:0]          inst,
    output logic [31:0]          inst_pc
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] ALMOST_FULL = (AW + 1)'(DEPTH - 1);

    fetch_state_t state, state_next;
    logic [31:0]  fetch_pc, fetch_pc_next;
    logic [31:0]  mem_addr_q, mem_addr_next;
    logic [31:0]  target;
    logic [31:0]  pc_inc;
    logic         push, pop, flush, full, empty;
    logic [AW:0]  count;
    fetch_entry_t head, wdata;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk             (clk),
        .rst             (rst),
        .push            (push),
        .pop             (pop),
        .flush_keep_none (flush),
        .wdata           (wdata),
        .head            (head),
        .full            (full),
        .empty           (empty),
        .count           (count)
    );

    assign target     = redirect_pc & 32'hFFFF_FFFC;
    assign pc_inc     = fetch_pc + 32'd4;
    assign pop        = !empty && !stall;
    assign flush      = redirect;
    assign wdata.pc   = fetch_pc;
    assign wdata.inst = mem.mem_rdata;

    assign mem.mem_req  = (state != IDLE);
    assign mem.mem_addr = mem_addr_q;

    assign inst_valid = !empty;
    assign inst       = empty ? NOP_INST : head.inst;
    assign inst_pc    = empty ? 32'h0 : head.pc;

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        mem_addr_next = mem_addr_q;
        push          = 1'b0;
        case (state)
            IDLE: begin
                if (redirect) begin
                    state_next    = WAIT;
                    fetch_pc_next = target;
                    mem_addr_next = target;
                end else if (!full) begin
                    state_next    = WAIT;
                    mem_addr_next = fetch_pc;
                end
            end
            WAIT: begin
                if (redirect) begin
                    // Keep the abandoned address on the bus until memory completes it.
                    fetch_pc_next = target;
                    if (mem.mem_ack) mem_addr_next = target;
                    else             state_next    = DROP;
                end else if (mem.mem_ack) begin
                    push          = 1'b1;
                    fetch_pc_next = pc_inc;
                    mem_addr_next = pc_inc;
                    // The next request reserves a slot, so issue only if one stays free.
                    if (!pop && (count >= ALMOST_FULL)) state_next = IDLE;
                end
            end
            DROP: begin
                if (redirect) fetch_pc_next = target;
                if (mem.mem_ack) begin
                    state_next    = WAIT;
                    mem_addr_next = redirect ? target : fetch_pc;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            fetch_pc   <= RESET_PC;
            mem_addr_q <= RESET_PC;
        end else begin
            state      <= state_next;
            fetch_pc   <= fetch_pc_next;
            mem_addr_q <= mem_addr_next;
        end
    end

endmodule
